seq_1010_gen: RTL and testbench
===============================

SEQ_1010_GEN -- requirements
Module: seq_1010_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the maximum word length in bits.
REQ-002 SHALL have parameter GAP, default 2, meaning the number of idle cycles inserted between repeated words (0 = back-to-back).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  transfer request, sampled on the rising edge of clk.
REQ-006 SHALL have port data  input  WIDTH  word to serialize; bit len-1 is sent first.
REQ-007 SHALL have port len  input  4  number of bits to send.
REQ-008 SHALL have port rep  input  2  repeat count; the word is sent rep+1 times.
REQ-009 SHALL have port x  output  1  serial bit, compatible with the 1010 sequence detector input.
REQ-010 SHALL have port valid  output  1  high while x carries a data bit.
REQ-011 SHALL have port busy  output  1  high from the first data bit through the done cycle.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, SHIFT, GAP_ST, DONE; all outputs SHALL be registered and decoded from state and internal registers only.
REQ-014 SHALL behave as follows in IDLE: x=0, valid=0, busy=0, done=0; start=1 at an edge captures data, len and rep and enters SHIFT.
REQ-015 SHALL, on the edge after start is sampled, present x=data[L-1] with valid=1, then one bit per cycle down to data[0].
REQ-016 SHALL use L=WIDTH when len=0 and clamp L to WIDTH when len>WIDTH; otherwise L=len.
REQ-017 SHALL, after data[0], enter GAP_ST if repetitions remain, holding x=0, valid=0, busy=1 for GAP cycles before re-entering SHIFT at bit L-1; when GAP=0, SHALL go directly from SHIFT to SHIFT.
REQ-018 SHALL, after the last bit of the last repetition, enter DONE for exactly one cycle with done=1, busy=1, valid=0, x=0, then return to IDLE.
REQ-019 SHALL complete a transfer in (rep+1)*L + rep*GAP data/gap cycles followed by one DONE cycle.
REQ-020 SHALL ignore start in SHIFT, GAP_ST and DONE, and SHALL ignore changes on data, len and rep while busy.
REQ-021 SHALL, with start held high continuously, accept the next transfer only from IDLE, guaranteeing at least one IDLE cycle between transfers.
REQ-022 SHALL use a bit counter and a repetition counter sized for L up to WIDTH and rep up to 3, with no wrap-around beyond these limits.

Reset
REQ-023 SHALL, while reset=0, immediately force the IDLE state and drive x=0, valid=0, busy=0, done=0, with all counters cleared, regardless of clk.
REQ-024 SHALL, on reset asserted mid-transfer, abort the transfer with no done pulse; the first start after reset release SHALL begin a fresh transfer.

Verification
REQ-025 SHALL pass: data=8'h0A, len=4, rep=0, start pulsed at edge T -> x=1,0,1,0 with valid=1 after edges T+1..T+4, done=1 after edge T+5, busy=1 T+1..T+5; a detector fed with x flags found after the fourth bit.
REQ-026 SHALL pass: data=8'h0A, len=4, rep=2, GAP=2 -> x sequence 1010 00 1010 00 1010 (16 cycles), valid low on the gap cycles, a single done pulse afterwards.
REQ-027 SHALL pass: data=8'hA5 with len=0, and again with len=12 -> both send 1,0,1,0,0,1,0,1 (8 bits).
REQ-028 SHALL pass: reset driven low after the third bit of a transfer -> x, valid, busy and done go to 0 at once with no done pulse; a later start sends the full word correctly.
REQ-029 SHALL pass: start pulsed while busy -> ignored; start held high for 20 cycles with len=4, rep=0 -> back-to-back transfers separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/seq_1010_gen.sv
// seq_1010_gen: serializes a word MSB-first, optionally repeated with idle gaps, for a 1010 detector
// Ports: clk; reset (async, active low); start, data[WIDTH-1:0], len[3:0], rep[1:0] (request);
//        x (serial bit), valid (x carries data), busy (first bit through done), done (completion pulse)
module seq_1010_gen #(
  parameter int WIDTH = 8,
  parameter int GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  input  logic [1:0]       rep,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_ST, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] word, word_n;
  logic [CW-1:0] top, top_n, cnt, cnt_n, len_top;
  logic [1:0] rc, rc_n;
  logic [GW-1:0] gc, gc_n;
  // index of the first bit sent: len of 0 or beyond WIDTH means a full word
  assign len_top = (len == 4'd0 || 32'(len) > WIDTH) ? CW'(WIDTH - 1) : CW'(len - 4'd1);
  always_comb begin
    state_n = state;
    word_n = word;
    top_n = top;
    cnt_n = cnt;
    rc_n = rc;
    gc_n = gc;
    case (state)
      IDLE: if (start) begin
        state_n = SHIFT;
        word_n = data;
        top_n = len_top;
        cnt_n = len_top;
        rc_n = rep;
      end
      SHIFT: if (cnt != '0) cnt_n = cnt - CW'(1);
      else if (rc != 2'd0) begin
        rc_n = rc - 2'd1;
        cnt_n = top;
        gc_n = GW'(GAP > 0 ? GAP - 1 : 0);
        state_n = GAP > 0 ? GAP_ST : SHIFT;
      end else state_n = DONE;
      GAP_ST: if (gc == '0) state_n = SHIFT;
      else gc_n = gc - GW'(1);
      DONE: state_n = IDLE;
    endcase
  end
  // outputs are a registered decode of the current state, so they trail the state by one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      word <= '0;
      top <= '0;
      cnt <= '0;
      rc <= '0;
      gc <= '0;
      x <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      word <= word_n;
      top <= top_n;
      cnt <= cnt_n;
      rc <= rc_n;
      gc <= gc_n;
      x <= state == SHIFT && word[cnt];
      valid <= state == SHIFT;
      busy <= state != IDLE;
      done <= state == DONE;
    end
  end
endmodule

// File: tb/tb_seq_1010_gen.sv
// tb_seq_1010_gen: scoreboard bench for seq_1010_gen
module tb_seq_1010_gen;
  localparam int GAP = 2;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [7:0] data = 0;
  logic [3:0] len = 0;
  logic [1:0] rep = 0;
  logic x, valid, busy, done;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] sb[$];
  logic [3:0] e;
  always #5 clk = ~clk;
  seq_1010_gen #(.WIDTH(8), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .len(len), .rep(rep),
    .x(x), .valid(valid), .busy(busy), .done(done)
  );
  // expected {x,valid,busy,done} per cycle from the first data bit to the idle cycle after done
  task automatic push_xfer(input logic [7:0] d, input logic [3:0] ln, input logic [1:0] rp);
    int l;
    l = (ln == 0 || ln > 8) ? 8 : int'(ln);
    for (int r = 0; r <= int'(rp); r++) begin
      for (int i = l - 1; i >= 0; i--) sb.push_back({d[i], 3'b110});
      if (r < int'(rp)) repeat (GAP) sb.push_back(4'b0010);
    end
    sb.push_back(4'b0011);
    sb.push_back(4'b0000);
  endtask
  task automatic drive(input logic [7:0] d, input logic [3:0] ln, input logic [1:0] rp);
    @(negedge clk);
    data = d;
    len = ln;
    rep = rp;
    start = 1;
  endtask
  task automatic test_reset;
    #3 reset = 0;
    #1;
    n_chk++;
    if ({x, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got xvbd=%b expected 0000", {x, valid, busy, done});
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if ({x, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: got xvbd=%b expected 0000", {x, valid, busy, done});
    end
    reset = 1;
    @(negedge clk);
    n_chk++;
    if ({x, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got xvbd=%b expected 0000", {x, valid, busy, done});
    end
  endtask
  task automatic test_basic;
    logic [3:0] hist;
    int k;
    hist = 0;
    k = 0;
    sb.push_back(4'b0000);
    push_xfer(8'h0A, 4'd4, 2'd0);
    drive(8'h0A, 4'd4, 2'd0);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 0;
      e = sb.pop_front();
      hist = {hist[2:0], x};
      n_chk++;
      if ({x, valid, busy, done} !== e) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got xvbd=%b expected %b", k, {x, valid, busy, done}, e);
      end
      if (k == 4) begin
        n_chk++;
        if (hist !== 4'b1010) begin
          n_fail++;
          $display("FAIL detect_1010: got %b expected 1010", hist);
        end
      end
      k++;
    end
  endtask
  task automatic test_xfer(input logic [7:0] d, input logic [3:0] ln, input logic [1:0] rp);
    int k;
    k = 0;
    sb.push_back(4'b0000);
    push_xfer(d, ln, rp);
    drive(d, ln, rp);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 0;
      e = sb.pop_front();
      n_chk++;
      if ({x, valid, busy, done} !== e) begin
        n_fail++;
        $display("FAIL xfer d=%h len=%0d rep=%0d cyc %0d: got xvbd=%b expected %b", d, ln, rp, k, {x, valid, busy, done}, e);
      end
      k++;
    end
  endtask
  task automatic test_abort;
    sb.push_back(4'b0000);
    sb.push_back(4'b1110);
    sb.push_back(4'b0110);
    sb.push_back(4'b1110);
    drive(8'hA5, 4'd0, 2'd0);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 0;
      e = sb.pop_front();
      n_chk++;
      if ({x, valid, busy, done} !== e) begin
        n_fail++;
        $display("FAIL abort_pre: got xvbd=%b expected %b", {x, valid, busy, done}, e);
      end
    end
    #1 reset = 0;
    #1;
    n_chk++;
    if ({x, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_async: got xvbd=%b expected 0000", {x, valid, busy, done});
    end
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if ({x, valid, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL abort_hold: got xvbd=%b expected 0000", {x, valid, busy, done});
      end
    end
    reset = 1;
    @(negedge clk);
    n_chk++;
    if ({x, valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_no_done: got xvbd=%b expected 0000", {x, valid, busy, done});
    end
  endtask
  task automatic test_ignore;
    int k;
    k = 0;
    sb.push_back(4'b0000);
    push_xfer(8'h0A, 4'd4, 2'd0);
    sb.push_back(4'b0000);
    drive(8'h0A, 4'd4, 2'd0);
    while (sb.size() > 0) begin
      @(negedge clk);
      if (k == 2) begin
        start = 1;
        data = 8'hFF;
        len = 4'd8;
        rep = 2'd3;
      end else start = k == 4;
      e = sb.pop_front();
      n_chk++;
      if ({x, valid, busy, done} !== e) begin
        n_fail++;
        $display("FAIL ignore_start cyc %0d: got xvbd=%b expected %b", k, {x, valid, busy, done}, e);
      end
      k++;
    end
  endtask
  task automatic test_back_to_back;
    int k;
    k = 0;
    sb.push_back(4'b0000);
    repeat (4) push_xfer(8'h0A, 4'd4, 2'd0);
    drive(8'h0A, 4'd4, 2'd0);
    while (sb.size() > 0) begin
      @(negedge clk);
      if (k == 19) start = 0;
      e = sb.pop_front();
      n_chk++;
      if ({x, valid, busy, done} !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got xvbd=%b expected %b", k, {x, valid, busy, done}, e);
      end
      k++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_basic;
    test_xfer(8'h0A, 4'd4, 2'd2);
    test_xfer(8'hA5, 4'd0, 2'd0);
    test_xfer(8'hA5, 4'd12, 2'd0);
    test_xfer(8'hF5, 4'd3, 2'd3);
    test_xfer(8'h01, 4'd1, 2'd1);
    test_abort;
    test_xfer(8'hA5, 4'd8, 2'd0);
    test_ignore;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
